// File: rtl/alu_adder_seq_if.sv
// rtl/alu_adder_seq_if.sv - request/operand handshake and status bundle for alu_adder_seq
interface alu_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output start, sub, acc, a, b, cin,
    input  busy, done, zero
  );

  modport slave (
    input  start, sub, acc, a, b, cin,
    output busy, done, zero
  );
endinterface

// File: rtl/alu_adder_seq.sv
// rtl/alu_adder_seq.sv - multi-cycle sliced add/subtract unit; ALU_ADDER_SEQ_ACC_EN enables accumulate operand
module alu_adder_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_adder_seq_if.slave   bus,
  input  logic             en,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             over
);
  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             over_reg;
  logic             zero_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] next_work;
  logic             c_msb;
  logic             c_out;

  // Current slice sum; carry into the MSB is recovered as a^b^sum at the top bit.
  always_comb begin
    a_sl      = op_a[idx*SLICE +: SLICE];
    b_sl      = op_b[idx*SLICE +: SLICE];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
    next_work = work;
    next_work[idx*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    c_out     = slice_sum[SLICE];
    c_msb     = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_sum[SLICE-1];
  end

`ifdef ALU_ADDER_SEQ_ACC_EN
  logic [WIDTH-1:0] a_src;
  assign a_src = bus.acc ? s_reg : bus.a;
`else
  logic [WIDTH-1:0] a_src;
  logic             unused_acc;
  assign a_src      = bus.a;
  assign unused_acc = bus.acc;
`endif

  // Control FSM, slice datapath and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
      over_reg <= 1'b0;
      zero_reg <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state    <= RUN;
            busy_reg <= 1'b1;
            op_a     <= a_src;
            op_b     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.cin;
            idx      <= '0;
          end else begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end
        RUN: begin
          work  <= next_work;
          carry <= c_out;
          if (idx == LAST) begin
            state    <= DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            s_reg    <= next_work;
            cout_reg <= c_out;
            over_reg <= c_msb ^ c_out;
            zero_reg <= (next_work == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.zero = zero_reg;

  // Shared result bus: driven only while enabled.
  assign s    = en ? s_reg    : {WIDTH{1'bz}};
  assign cout = en ? cout_reg : 1'bz;
  assign over = en ? over_reg : 1'bz;
endmodule

// File: tb/tb_alu_adder_seq.sv
// tb/tb_alu_adder_seq.sv - directed-vector bench for alu_adder_seq
module tb_alu_adder_seq;
  logic       clk;
  logic       rst_n;
  logic       en;
  wire  [7:0] s_w;
  wire        cout_w;
  wire        over_w;
  int         n_vec;
  int         n_err;

  alu_adder_seq_if #(.WIDTH(8)) bus ();

  alu_adder_seq #(.WIDTH(8), .SLICE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .en    (en),
    .s     (s_w),
    .cout  (cout_w),
    .over  (over_w)
  );

  // Released bus lines float high so a disabled driver is observable.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (s_w[i]);
  end
  pullup (cout_w);
  pullup (over_w);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                       input logic tsub, input logic tacc);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tcin;
    bus.sub   = tsub;
    bus.acc   = tacc;
    bus.start = 1'b1;
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tcin, input logic tsub, input logic tacc);
    int lat;
    @(negedge clk);
    drive(ta, tb_v, tcin, tsub, tacc);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    @(negedge clk);
    check({tag, "_done_width"}, {30'd0, bus.done, bus.busy}, 0);
  endtask

  logic [7:0] acc_exp;
  int         dones;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.acc   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
    check("rst_s", s_w, 8'h00);
    check("rst_flags", {29'd0, cout_w, over_w, bus.zero}, 3'b001);
    rst_n = 1'b1;

    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    check("add_7f_01_s", s_w, 8'h80);
    check("add_7f_01_flags", {29'd0, cout_w, over_w, bus.zero}, 3'b010);

    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check("add_ff_01_s", s_w, 8'h00);
    check("add_ff_01_flags", {29'd0, cout_w, over_w, bus.zero}, 3'b101);
    en = 1'b0;
    #1;
    check("en0_s_released", s_w, 8'hFF);
    check("en0_flags_released", {29'd0, cout_w, over_w, bus.zero}, 3'b111);
    en = 1'b1;
    #1;
    check("en1_s_restored", s_w, 8'h00);

    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    check("sub_05_07_s", s_w, 8'hFE);
    check("sub_05_07_flags", {29'd0, cout_w, over_w, bus.zero}, 3'b000);

    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    check("sub_80_01_s", s_w, 8'h7F);
    check("sub_80_01_flags", {29'd0, cout_w, over_w, bus.zero}, 3'b110);

    // Second start during RUN cycle 2 must be ignored.
    @(negedge clk);
    drive(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    drive(8'h55, 8'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("ignore_start_dones", dones, 1);
    check("ignore_start_busy", {31'd0, bus.busy}, 0);
    check("ignore_start_s", s_w, 8'h30);

    // Reset in the middle of RUN cycle 3.
    @(negedge clk);
    drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
    check("midrun_rst_s", s_w, 8'h00);
    check("midrun_rst_zero", {31'd0, bus.zero}, 1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    check("midrun_rst_no_done", dones, 0);
    do_op("after_rst", 8'h22, 8'h11, 1'b0, 1'b0, 1'b0);
    check("after_rst_s", s_w, 8'h33);

    do_op("acc_seed", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    check("acc_seed_s", s_w, 8'h30);
`ifdef ALU_ADDER_SEQ_ACC_EN
    acc_exp = 8'h35;
`else
    acc_exp = 8'h05;
`endif
    do_op("acc_op", 8'h00, 8'h05, 1'b0, 1'b0, 1'b1);
    check("acc_op_s", s_w, acc_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
